fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Write-side arbiter that shares one synchronous FIFO write port among NUM_REQ producers. A round-robin scheduler locks the FIFO to one producer for a bounded burst, drives the FIFO `wr_en`/`data_in`, and back-pressures every producer from the FIFO `full` flag. It sits between the producer blocks and a single `fifo_method1` instance. Producer bursts are kept contiguous in the FIFO, and no requester can starve another.

## Interface
- `NUM_REQ`, default 4: number of producers, must be ≥ 2.
- `DATA_WIDTH`, default 8: word width, must match the FIFO.
- `MAX_BURST`, default 4: maximum words accepted per grant, must be ≥ 1.

- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req_valid`, input, NUM_REQ: bit i means producer i has a word ready.
- `req_data`, input, NUM_REQ*DATA_WIDTH: producer i word at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`, output, NUM_REQ: bit i means producer i's word is consumed this cycle. At most one bit is high.
- `fifo_full`, input, 1: FIFO full flag. A FIFO of depth DEPTH holds DEPTH-1 words.
- `fifo_wr_en`, output, 1: FIFO write enable.
- `fifo_data_in`, output, DATA_WIDTH: FIFO write data.
- `grant_valid`, output, 1: high while a producer owns the port.
- `grant_id`, output, clog2(NUM_REQ): index of the current owner. Holds its last value when `grant_valid` is low.

## Operation
- Registered state:
  - FSM: IDLE or GRANT.
  - `owner`: clog2(NUM_REQ) bits.
  - `rr_ptr`: clog2(NUM_REQ) bits; the highest-priority index for the next arbitration.
  - `burst_cnt`: clog2(MAX_BURST+1) bits.
- IDLE:
  - If any `req_valid` bit is high, pick the first set index scanning `rr_ptr`, `rr_ptr`+1, … with modulo-NUM_REQ wrap.
  - Load that index into `owner`, clear `burst_cnt`, go to GRANT.
  - If no bit is high, stay in IDLE.
- GRANT transfer condition: xfer = `req_valid[owner]` && !`fifo_full`.
- Combinational outputs in GRANT:
  - `fifo_wr_en` = xfer.
  - `req_ready[owner]` = xfer; all other `req_ready` bits are 0.
  - `fifo_data_in` = the owner's word. It is driven with the owner's word in every GRANT cycle; in IDLE it is 0.
- On every transfer, `burst_cnt` increments by 1.
- Release to IDLE, with `rr_ptr` <= (`owner`+1) mod NUM_REQ, on the first of:
  - a transfer that brings `burst_cnt` to MAX_BURST (the last word is written in that same cycle);
  - a cycle with `req_valid[owner]` low (no transfer in that cycle).
- `fifo_full` high with the owner valid is a stall:
  - no transfer;
  - no release;
  - `burst_cnt` holds.
- Requests from non-owners are ignored during GRANT. Producers must hold valid and data stable until they see ready.
- Words are never dropped or duplicated. Every `req_ready` pulse corresponds to exactly one `fifo_wr_en` pulse.

## Timing
- Reset values:
  - FSM = IDLE;
  - `rr_ptr` = 0, `owner` = 0, `burst_cnt` = 0;
  - `grant_valid` = 0, `grant_id` = 0;
  - `fifo_wr_en` = 0, `req_ready` = 0, `fifo_data_in` = 0.
- Reset mid-burst:
  - Outputs are deasserted in the cycle `rst` is sampled high.
  - No write is issued in that cycle.
  - Arbitration restarts from index 0 after reset.
- Arbitration latency:
  - `req_valid` is seen in IDLE at edge N; GRANT begins in cycle N+1.
  - The first write can occur in cycle N+1.
- Throughput:
  - one word per cycle during a grant;
  - one IDLE bubble cycle after every release.
- `fifo_full` is used combinationally in the same cycle. If `fifo_full` is high, `fifo_wr_en` is low in that cycle.
- `grant_valid` and `grant_id` are registered from the FSM state and `owner`. They change one cycle after the arbitration or release decision.

## Test plan
- Single burst split by MAX_BURST:
  - Stimulus: MAX_BURST=4; producer 1 holds valid for 6 words (0x10..0x15).
  - Response: writes 0x10..0x13 on consecutive cycles, then 1 IDLE cycle, then a re-grant to producer 1 and writes 0x14, 0x15, then a release on valid low.
- Round-robin fairness:
  - Stimulus: all 4 producers continuously valid, each with 8 words.
  - Response: grant order 0,1,2,3,0,1,2,3; 4 words per grant; FIFO contents grouped per producer in that order.
- Full stall:
  - Stimulus: `fifo_full` held high for 3 cycles mid-burst after 2 words.
  - Response: `fifo_wr_en` and `req_ready` stay low for those 3 cycles; `grant_id` is unchanged; the remaining 2 words are written after full drops.
- Early release:
  - Stimulus: producer 2 drops valid after 1 word while producer 3 is waiting.
  - Response: release; `rr_ptr`=3; producer 3 is granted next with no write from producer 2.
- Reset mid-burst:
  - Stimulus: `rst` asserted during producer 3's 2nd word.
  - Response: no write in that cycle; all outputs 0; after reset, producers 0 and 3 both valid → producer 0 is granted first.
- Wrap-around:
  - Stimulus: `rr_ptr`=3; only producers 1 and 3 valid.
  - Response: producer 3 is granted first, then producer 1.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one synchronous FIFO write
// port among NUM_REQ producers. A grant locks the port to one producer for at
// most MAX_BURST words so bursts stay contiguous in the FIFO, and the
// round-robin pointer guarantees no producer can starve another.
//
// Handshake (both sides): a word moves in a cycle exactly when the producer
// holds req_valid_i[i] high and req_ready_o[i] is high in that same cycle;
// that same cycle fifo_wr_en_o is high with the word on fifo_data_in_o.
// Producers keep valid and data stable until they see ready.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNTW      = $clog2(MAX_BURST + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          fifo_full_i,
    output logic                          fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]         fifo_data_in_o,
    output logic                          grant_valid_o,
    output logic [IDW-1:0]                grant_id_o,
    output logic                          dbg_state_o
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNTW-1:0] burst_cnt_q, burst_cnt_d;
    logic            grant_valid_q;
    logic [IDW-1:0]  grant_id_q;

    logic                  xfer;
    logic                  pick_found;
    logic [IDW-1:0]        pick_idx;
    logic [IDW:0]          cand;
    logic [IDW-1:0]        owner_next;
    logic [DATA_WIDTH-1:0] owner_word;

    // Select the current owner's word from the flattened producer bus.
    always_comb begin
        owner_word = req_data_i[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin pick: first valid index scanning rr_ptr, rr_ptr+1, ... with wrap.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(NUM_REQ)) begin
                cand = cand - (IDW+1)'(NUM_REQ);
            end
            if (!pick_found && req_valid_i[cand[IDW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IDW-1:0];
            end
        end
    end

    // Pointer value handed to the next arbitration when the owner releases.
    always_comb begin
        owner_next = (owner_q == IDW'(NUM_REQ - 1)) ? '0 : owner_q + IDW'(1);
    end

    // FSM next state and write-port outputs; reset forces all outputs low.
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        rr_ptr_d       = rr_ptr_q;
        burst_cnt_d    = burst_cnt_q;
        xfer           = 1'b0;
        req_ready_o    = '0;
        fifo_wr_en_o   = 1'b0;
        fifo_data_in_o = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d     = ST_GRANT;
                    owner_d     = pick_idx;
                    burst_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                fifo_data_in_o       = owner_word;
                xfer                 = req_valid_i[owner_q] && !fifo_full_i;
                fifo_wr_en_o         = xfer;
                req_ready_o[owner_q] = xfer;
                if (xfer) begin
                    burst_cnt_d = burst_cnt_q + CNTW'(1);
                    // Last word of the burst is written in the releasing cycle.
                    if (burst_cnt_q == CNTW'(MAX_BURST - 1)) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = owner_next;
                    end
                end else if (!req_valid_i[owner_q]) begin
                    // Owner has nothing more to send; a full stall does not release.
                    state_d  = ST_IDLE;
                    rr_ptr_d = owner_next;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (rst_i) begin
            req_ready_o    = '0;
            fifo_wr_en_o   = 1'b0;
            fifo_data_in_o = '0;
        end
    end

    // State registers; grant status lags the FSM by one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            owner_q       <= '0;
            rr_ptr_q      <= '0;
            burst_cnt_q   <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            burst_cnt_q   <= burst_cnt_d;
            grant_valid_q <= (state_q == ST_GRANT);
            if (state_q == ST_GRANT) begin
                grant_id_q <= owner_q;
            end
        end
    end

    assign grant_valid_o = grant_valid_q & ~rst_i;
    assign grant_id_o    = rst_i ? '0 : grant_id_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4).
module tb_fifo_wr_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic             fifo_full;
    logic             fifo_wr_en;
    logic [DW-1:0]    fifo_data_in;
    logic             grant_valid;
    logic [1:0]       grant_id;
    logic             dbg_state;

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_data_i     (req_data),
        .req_ready_o    (req_ready),
        .fifo_full_i    (fifo_full),
        .fifo_wr_en_o   (fifo_wr_en),
        .fifo_data_in_o (fifo_data_in),
        .grant_valid_o  (grant_valid),
        .grant_id_o     (grant_id),
        .dbg_state_o    (dbg_state)
    );

    int total = 0;
    int bad   = 0;
    int n_wr  = 0;
    logic [DW-1:0] exp_q[$];
    int       sent[NR];
    int       nwords[NR];
    logic [7:0] base[NR];
    logic     full_cmd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // producer model drives valid/data from its word counters
    task automatic drive();
        for (int p = 0; p < NR; p++) begin
            req_valid[p] = (sent[p] < nwords[p]);
            req_data[p*DW +: DW] = base[p] + 8'(sent[p]);
        end
        fifo_full = full_cmd;
    endtask

    task automatic clear_producers();
        for (int p = 0; p < NR; p++) begin
            sent[p]   = 0;
            nwords[p] = 0;
            base[p]   = 8'h00;
        end
    endtask

    // one clock: score this cycle's write, advance producers, apply inputs
    task automatic tick();
        logic [NR-1:0] rdy_s;
        logic          wr_s;
        logic [DW-1:0] d_s;
        logic [DW-1:0] e;
        rdy_s = req_ready;
        wr_s  = fifo_wr_en;
        d_s   = fifo_data_in;
        chk("rdy_onehot0", 32'($onehot0(rdy_s)), 32'd1);
        chk("rdy_vs_wr", 32'(|rdy_s), 32'(wr_s));
        if (wr_s) begin
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL sb_extra_write observed=%0h expected=no_write", d_s);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_word", 32'(d_s), 32'(e));
                n_wr++;
            end
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < NR; p++) begin
            if (rdy_s[p]) sent[p]++;
        end
        drive();
        #1;
    endtask

    task automatic chk_out(input string tag, input logic wr, input logic [7:0] d, input logic [3:0] rdy);
        chk({tag, "_wr"}, 32'(fifo_wr_en), 32'(wr));
        chk({tag, "_data"}, 32'(fifo_data_in), 32'(d));
        chk({tag, "_rdy"}, 32'(req_ready), 32'(rdy));
    endtask

    task automatic chk_grant(input string tag, input logic gv, input logic [1:0] gid);
        chk({tag, "_gv"}, 32'(grant_valid), 32'(gv));
        chk({tag, "_gid"}, 32'(grant_id), 32'(gid));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        full_cmd = 1'b0;
        clear_producers();
        drive();
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() > 0; i++) tick();
        chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 4; i++) tick();
    endtask

    initial begin
        rst = 1'b1;
        full_cmd = 1'b0;
        clear_producers();
        drive();
        #1;
        do_reset();

        // reset values
        chk_out("reset", 1'b0, 8'h00, 4'b0000);
        chk_grant("reset", 1'b0, 2'd0);
        chk("reset_state", 32'(dbg_state), 32'd0);

        // single burst from producer 1 split by MAX_BURST
        nwords[1] = 6; base[1] = 8'h10; drive(); #1;
        for (int k = 0; k < 6; k++) exp_q.push_back(8'h10 + 8'(k));
        chk_out("b1_idle", 1'b0, 8'h00, 4'b0000); tick();
        chk_out("b1_w0", 1'b1, 8'h10, 4'b0010); chk_grant("b1_w0", 1'b0, 2'd0); tick();
        chk_out("b1_w1", 1'b1, 8'h11, 4'b0010); tick();
        chk_out("b1_w2", 1'b1, 8'h12, 4'b0010); tick();
        chk_out("b1_w3", 1'b1, 8'h13, 4'b0010); chk_grant("b1_w3", 1'b1, 2'd1); tick();
        chk_out("b1_bubble", 1'b0, 8'h00, 4'b0000); tick();
        chk_out("b1_w4", 1'b1, 8'h14, 4'b0010); chk_grant("b1_w4", 1'b0, 2'd1); tick();
        chk_out("b1_w5", 1'b1, 8'h15, 4'b0010); tick();
        chk_out("b1_rel", 1'b0, 8'h16, 4'b0000); tick();
        chk_out("b1_after", 1'b0, 8'h00, 4'b0000);
        drain("b1", 10);

        // round-robin fairness: all four valid, 8 words each
        do_reset();
        n_wr = 0;
        for (int p = 0; p < NR; p++) begin
            nwords[p] = 8;
            base[p] = 8'h40 + 8'(p * 16);
        end
        drive(); #1;
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < NR; p++)
                for (int k = 0; k < 4; k++)
                    exp_q.push_back(8'h40 + 8'(p * 16) + 8'(r * 4 + k));
        drain("rr", 100);
        chk("rr_count", 32'(n_wr), 32'd32);

        // full stall mid-burst
        do_reset();
        nwords[1] = 4; base[1] = 8'h60; drive(); #1;
        for (int k = 0; k < 4; k++) exp_q.push_back(8'h60 + 8'(k));
        chk_out("st_idle", 1'b0, 8'h00, 4'b0000); tick();
        chk_out("st_w0", 1'b1, 8'h60, 4'b0010); tick();
        chk_out("st_w1", 1'b1, 8'h61, 4'b0010);
        full_cmd = 1'b1; tick();
        for (int c = 0; c < 3; c++) begin
            chk_out("st_stall", 1'b0, 8'h62, 4'b0000);
            chk_grant("st_stall", 1'b1, 2'd1);
            if (c == 2) full_cmd = 1'b0;
            tick();
        end
        chk_out("st_w2", 1'b1, 8'h62, 4'b0010); tick();
        chk_out("st_w3", 1'b1, 8'h63, 4'b0010); tick();
        chk_out("st_rel", 1'b0, 8'h00, 4'b0000);
        drain("st", 10);

        // early release of producer 2, producer 3 waiting, producer 0 late
        do_reset();
        nwords[2] = 1; base[2] = 8'h70;
        nwords[3] = 2; base[3] = 8'h80;
        drive(); #1;
        exp_q.push_back(8'h70); exp_q.push_back(8'h80);
        exp_q.push_back(8'h81); exp_q.push_back(8'h90);
        chk_out("er_idle", 1'b0, 8'h00, 4'b0000); tick();
        chk_out("er_p2", 1'b1, 8'h70, 4'b0100);
        nwords[0] = 1; base[0] = 8'h90; tick();
        chk_out("er_rel", 1'b0, 8'h71, 4'b0000); tick();
        chk_out("er_bubble", 1'b0, 8'h00, 4'b0000); chk_grant("er_bubble", 1'b1, 2'd2); tick();
        chk_out("er_p3a", 1'b1, 8'h80, 4'b1000); tick();
        chk_out("er_p3b", 1'b1, 8'h81, 4'b1000); chk_grant("er_p3b", 1'b1, 2'd3); tick();
        chk_out("er_rel3", 1'b0, 8'h82, 4'b0000); tick();
        chk_out("er_bubble2", 1'b0, 8'h00, 4'b0000); tick();
        chk_out("er_p0", 1'b1, 8'h90, 4'b0001);
        drain("er", 10);

        // reset during producer 3's second word
        do_reset();
        nwords[3] = 4; base[3] = 8'hA0; drive(); #1;
        exp_q.push_back(8'hA0);
        chk_out("rm_idle", 1'b0, 8'h00, 4'b0000); tick();
        chk_out("rm_w0", 1'b1, 8'hA0, 4'b1000); tick();
        rst = 1'b1; #1;
        chk_out("rm_rst", 1'b0, 8'h00, 4'b0000);
        chk_grant("rm_rst", 1'b0, 2'd0);
        tick();
        rst = 1'b0;
        nwords[0] = 1; base[0] = 8'hB0; drive(); #1;
        exp_q.push_back(8'hB0); exp_q.push_back(8'hA1);
        exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
        chk("rm_post_state", 32'(dbg_state), 32'd0);
        chk_out("rm_arb", 1'b0, 8'h00, 4'b0000); tick();
        chk_out("rm_p0", 1'b1, 8'hB0, 4'b0001);
        drain("rm", 20);

        // wrap-around: rr_ptr=3 with only producers 1 and 3 valid
        do_reset();
        nwords[2] = 1; base[2] = 8'hC0; drive(); #1;
        exp_q.push_back(8'hC0); exp_q.push_back(8'hD0); exp_q.push_back(8'hE0);
        chk_out("wr_idle", 1'b0, 8'h00, 4'b0000); tick();
        chk_out("wr_p2", 1'b1, 8'hC0, 4'b0100);
        nwords[3] = 1; base[3] = 8'hD0;
        nwords[1] = 1; base[1] = 8'hE0; tick();
        chk_out("wr_rel", 1'b0, 8'hC1, 4'b0000); tick();
        chk_out("wr_bubble", 1'b0, 8'h00, 4'b0000); tick();
        chk_out("wr_p3", 1'b1, 8'hD0, 4'b1000); tick();
        chk_out("wr_rel3", 1'b0, 8'hD1, 4'b0000); tick();
        chk_out("wr_bubble2", 1'b0, 8'h00, 4'b0000); tick();
        chk_out("wr_p1", 1'b1, 8'hE0, 4'b0010);
        drain("wr", 10);
        chk_grant("wr_final", 1'b0, 2'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
